multi_ctrl: RTL and testbench
=============================

# multi_ctrl

Sequencer for the RV64M unit in the execute stage, directly upstream of the pipelined multiplier. It accepts one M-extension op at a time from EX and drives the multiplier's two-phase operand/control timing. It runs DIV/DIVU/REM/REMU(+W) on an internal iterative divider. It returns a single-cycle `valid_out` pulse with the 64-bit result and holds `busy` to stall the pipeline while an op is in flight.

## Interface
Parameters:
- `XLEN`, 64, datapath width; only 64 is supported.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `valid_in`  in  1  op request from EX
- `funct3`  in  3  M-ext funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `is_w`  in  1  *W variant (MULW/DIVW/...)
- `src1_in`, `src2_in`  in  64  operands
- `flush`  in  1  abort in-flight op, synchronous
- `mul_result`  in  64  registered multiplier output
- `mul_src1`, `mul_src2`  out  64  multiplier operands, pass-through of `src1_in`/`src2_in`
- `mul_ALUctr_in`  out  2  `funct3[1:0]`, combinational
- `mul_ALUctr`  out  2  `funct3[1:0]` of the accepted mul op, registered
- `mul_is_w`  out  1  `is_w` of the accepted mul op, registered
- `mul_block`  out  1  multiplier operand-register hold
- `busy`  out  1  unit occupied; EX must hold its op
- `valid_out`  out  1  one-cycle result pulse
- `result`  out  64  result, valid when `valid_out`

## Operation
- Accept: `valid_in & ~busy & ~flush`. While `busy`, `valid_in` is ignored and EX holds its request.
- `mul_block` = 0 only in the cycle a mul op (funct3[2]=0) is accepted; 1 in every other cycle.
- FSM states:
  - IDLE: accept mul → MUL1; accept div → DIV.
  - MUL1 → DONE.
  - DIV: stays 64 cycles, counter 63→0; the special case (below) skips the iteration; → FIX.
  - FIX: sign correction → DONE.
  - DONE behaves as IDLE, and may accept a new op.
- `busy` = state ∈ {MUL1, DIV, FIX}.
- `valid_out` = state == DONE.
- In DONE, `result` = `mul_result` for mul ops and the divider register for div ops.
- Divide operands:
  - `is_w`: low 32 bits, sign-extended (DIV/REM) or zero-extended (DIVU/REMU).
  - Signed ops divide magnitudes. Quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - Restoring radix-2: 65-bit partial remainder, one quotient bit per cycle.
- Special cases, decided at accept; they bypass the 64 iterations and go straight to FIX:
  - Divisor 0: quotient = all-ones, remainder = dividend.
  - Signed overflow (most-negative / −1, at 64- or 32-bit width per `is_w`): quotient = dividend, remainder = 0.
- `is_w` results (div and rem): sign-extended from bit 31. Mul W results come from the multiplier.
- `flush`, and `rst`, in any state: → IDLE next edge, no `valid_out` for the aborted op. `flush` beats a simultaneous `valid_in`.
- Reset values: `valid_out` 0, `busy` 0, `result` 0, `mul_ALUctr` 0, `mul_is_w` 0, state IDLE, divider regs 0.

## Timing
- Mul accepted in cycle 0:
  - Multiplier latches sources at the end of cycle 0.
  - `mul_ALUctr`/`mul_is_w` are valid throughout cycle 1.
  - `valid_out` in cycle 2.
  - Latency 2.
- Div, normal: accept cycle 0; iterations in cycles 1–64; FIX in cycle 65; `valid_out` in cycle 66.
- Div, special case: accept cycle 0; FIX in cycle 1; `valid_out` in cycle 2.
- Back-to-back: a new op may be accepted in the DONE cycle. Its `mul_block` low and its `valid_out` timing count from that cycle.

## Structure
- Shared package `multi_pkg`: funct3 op constants, FSM state encoding, `XLEN`.
- One sub-module `div_radix2`: iterative unsigned core with start/done, 64-bit dividend/divisor in, quotient/remainder out.
- `multi_ctrl` owns: FSM, sign/width pre- and post-processing, special-case detection, result mux.

## Test plan
- MULH, src1=0xFFFF_FFFF_FFFF_FFFF, src2=2, accepted cycle 0 → `mul_block`=0 in cycle 0, `mul_ALUctr`=01 in cycle 1, `valid_out` in cycle 2, `result`=0xFFFF_FFFF_FFFF_FFFF.
- DIV, 0x…FFF9 (−7) / 2 → `valid_out` in cycle 66 with 0xFFFF_FFFF_FFFF_FFFD (−3); REM on the same operands → 0xFFFF_FFFF_FFFF_FFFF (−1).
- DIVU, x / 0 (x=5) → `valid_out` in cycle 2, result all-ones; REMU → 5.
- DIVW, 0x8000_0000 / 0xFFFF_FFFF → `valid_out` in cycle 2, result 0xFFFF_FFFF_8000_0000; REMW → 0.
- `flush` at cycle 30 of a DIV → no `valid_out`, `busy`=0 at cycle 31. A MUL accepted at cycle 31 completes at cycle 33.
- Mul in DONE of a prior div (back-to-back) → both `valid_out` pulses present, correct results. `valid_in` during `busy` is not accepted: `mul_block` stays 1.

Source files
------------

// File: rtl/multi_pkg.sv
// Shared definitions for the RV64M sequencer: datapath width, funct3 op codes,
// FSM state encoding and a small sign-extension helper.
package multi_pkg;
  localparam int XLEN = 64;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/div_radix2.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, XLEN cycles
// after start. done is high during the final iteration cycle.
module div_radix2 #(
  parameter int XLEN = multi_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);
  localparam int CW = $clog2(XLEN);

  logic            running;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvsr;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
  always_comb begin
    shifted = {remainder, quotient[XLEN-1]};
    trial   = shifted - {1'b0, dvsr};
  end

  assign done = running & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      running   <= 1'b0;
      cnt       <= '0;
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running   <= 1'b1;
      cnt       <= CW'(XLEN - 1);
      dvsr      <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (running) begin
      if (!trial[XLEN]) begin
        remainder <= trial[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end else begin
        remainder <= shifted[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
      if (cnt == '0) running <= 1'b0;
    end
  end
endmodule

// File: rtl/multi_ctrl.sv
// RV64M sequencer: drives the external pipelined multiplier's operand/control
// timing and runs divides on the internal radix-2 core with sign/width fix-up.
module multi_ctrl #(
  parameter int XLEN = multi_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [2:0]      funct3,
  input  logic            is_w,
  input  logic [XLEN-1:0] src1_in,
  input  logic [XLEN-1:0] src2_in,
  input  logic            flush,
  input  logic [XLEN-1:0] mul_result,
  output logic [XLEN-1:0] mul_src1,
  output logic [XLEN-1:0] mul_src2,
  output logic [1:0]      mul_ALUctr_in,
  output logic [1:0]      mul_ALUctr,
  output logic            mul_is_w,
  output logic            mul_block,
  output logic            busy,
  output logic            valid_out,
  output logic [XLEN-1:0] result
);
  import multi_pkg::*;

  state_t state;

  logic accept, acc_mul, acc_div;
  logic sgn, neg_a, neg_b, div_zero, ovf;
  logic [XLEN-1:0] a, b, mag_a, mag_b, sp_val;

  logic op_mul, op_rem, op_w, neg_q, neg_r, special;
  logic [XLEN-1:0] sp_res, div_res, fix_raw, fix_val;
  logic [XLEN-1:0] div_q, div_r;
  logic div_done;

  assign accept  = valid_in & ~busy & ~flush & ~rst;
  assign acc_mul = accept & ~funct3[2];
  assign acc_div = accept & funct3[2];

  assign mul_src1      = src1_in;
  assign mul_src2      = src2_in;
  assign mul_ALUctr_in = funct3[1:0];
  assign mul_block     = ~acc_mul;

  assign busy      = state inside {S_MUL1, S_DIV, S_FIX};
  assign valid_out = (state == S_DONE);
  assign result    = valid_out ? (op_mul ? mul_result : div_res) : '0;

  // Operand conditioning and special-case detection, evaluated in the accept cycle
  always_comb begin
    sgn      = ~funct3[0];
    a        = is_w ? (sgn ? sext32(src1_in[31:0]) : {32'h0, src1_in[31:0]}) : src1_in;
    b        = is_w ? (sgn ? sext32(src2_in[31:0]) : {32'h0, src2_in[31:0]}) : src2_in;
    neg_a    = sgn & a[XLEN-1];
    neg_b    = sgn & b[XLEN-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_zero = (b == '0);
    ovf      = sgn & (b == '1) &
               (a == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (div_zero) sp_val = funct3[1] ? a : '1;
    else          sp_val = funct3[1] ? '0 : a;
  end

  always_comb begin
    if (special)     fix_raw = sp_res;
    else if (op_rem) fix_raw = neg_r ? -div_r : div_r;
    else             fix_raw = neg_q ? -div_q : div_q;
    fix_val = op_w ? sext32(fix_raw[31:0]) : fix_raw;
  end

  div_radix2 #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (acc_div & ~(div_zero | ovf)),
    .abort     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mul_ALUctr <= '0;
      mul_is_w   <= 1'b0;
      op_mul     <= 1'b0;
      op_rem     <= 1'b0;
      op_w       <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      special    <= 1'b0;
      sp_res     <= '0;
      div_res    <= '0;
    end else begin
      if (acc_mul) begin
        mul_ALUctr <= funct3[1:0];
        mul_is_w   <= is_w;
      end
      if (accept) begin
        op_mul  <= ~funct3[2];
        op_rem  <= funct3[1];
        op_w    <= is_w;
        neg_q   <= neg_a ^ neg_b;
        neg_r   <= neg_a;
        special <= div_zero | ovf;
        sp_res  <= sp_val;
      end
      if (state == S_FIX) div_res <= fix_val;

      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (acc_mul)      state <= S_MUL1;
            else if (acc_div) state <= (div_zero | ovf) ? S_FIX : S_DIV;
            else              state <= S_IDLE;
          end
          S_MUL1:  state <= S_DONE;
          S_DIV:   if (div_done) state <= S_FIX;
          S_FIX:   state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multi_ctrl.sv
// Randomized and directed bench for multi_ctrl with a behavioural multiplier
// and a reference model built on native 64/32-bit arithmetic.
module tb_multi_ctrl;
  import multi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic        is_w = 1'b0;
  logic [63:0] src1_in = 64'h0;
  logic [63:0] src2_in = 64'h0;
  logic        flush = 1'b0;
  logic [63:0] mul_result;
  logic [63:0] mul_src1, mul_src2, result;
  logic [1:0]  mul_ALUctr_in, mul_ALUctr;
  logic        mul_is_w, mul_block, busy, valid_out;

  logic [63:0] ma = 64'h0;
  logic [63:0] mb = 64'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_ctrl dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .funct3(funct3), .is_w(is_w),
    .src1_in(src1_in), .src2_in(src2_in), .flush(flush), .mul_result(mul_result),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_ALUctr_in(mul_ALUctr_in),
    .mul_ALUctr(mul_ALUctr), .mul_is_w(mul_is_w), .mul_block(mul_block),
    .busy(busy), .valid_out(valid_out), .result(result)
  );

  function automatic logic [63:0] mul_fn(input logic [1:0] c, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p, sa, sb, ua, ub;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'h0, a};
    ub = {64'h0, b};
    case (c)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    if (w) return {{32{p[31]}}, p[31:0]};
    return (c == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  // Multiplier: latches operands when unblocked, registered result one cycle later
  always @(posedge clk) begin
    if (!mul_block) begin
      ma <= mul_src1;
      mb <= mul_src2;
    end
    mul_result <= mul_fn(mul_ALUctr, mul_is_w, ma, mb);
  end

  function automatic logic [63:0] ref_op(input logic [2:0] f, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    if (!f[2]) return mul_fn(f[1:0], w, a, b);
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'h0) begin q32 = 32'hFFFF_FFFF; r32 = a32; end
      else if (!f[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 32'h0; end
      else if (!f[0]) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      return f[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    if (b == 64'h0) begin q = '1; r = a; end
    else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 64'h0; end
    else if (!f[0]) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else begin q = a / b; r = a % b; end
    return f[1] ? r : q;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    if (w) return (b[31:0] == 32'h0) ||
                  (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'h0) || (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  // One op from an idle unit; counts cycles from accept to the valid_out pulse
  task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input bit use_exp,
                        input logic [63:0] exp_res, input int exp_lat_in);
    logic [63:0] exp_v, got;
    int exp_lat, lat;
    bit mul;
    mul = !f[2];
    got = 64'h0;
    lat = 0;
    exp_v   = use_exp ? exp_res : ref_op(f, w, a, b);
    exp_lat = use_exp ? exp_lat_in : ((mul || is_special(f, w, a, b)) ? 2 : 66);
    @(posedge clk); #1;
    valid_in = 1'b1; funct3 = f; is_w = w; src1_in = a; src2_in = b;
    @(negedge clk);
    checks++;
    if (mul_block !== !mul) begin
      errors++;
      $display("FAIL mul_block_accept f3=%0d w=%0d got %b want %b", f, w, mul_block, !mul);
    end
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      src1_in = {$urandom, $urandom};
      src2_in = {$urandom, $urandom};
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_cycle1 f3=%0d got %b want 1", f, busy);
        end
        if (mul) begin
          checks++;
          if ({mul_ALUctr, mul_is_w} !== {f[1:0], w}) begin
            errors++;
            $display("FAIL mul_ctrl_cycle1 f3=%0d got %b_%b want %b_%b", f, mul_ALUctr, mul_is_w, f[1:0], w);
          end
        end
      end
      if (valid_out) begin lat = k; got = result; end
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency f3=%0d w=%0d a=%h b=%h got %0d want %0d", f, w, a, b, lat, exp_lat);
    end
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL result f3=%0d w=%0d a=%h b=%h got %h want %h", f, w, a, b, got, exp_v);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_out, busy, mul_ALUctr, mul_is_w} !== 5'b0 || result !== 64'h0) begin
      errors++;
      $display("FAIL reset_state got vo=%b busy=%b ctr=%b w=%b res=%h want all zero",
               valid_out, busy, mul_ALUctr, mul_is_w, result);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_block !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got blk=%b busy=%b want 1 0", mul_block, busy);
    end
  endtask

  task automatic test_reset_midop;
    int vo;
    vo = 0;
    @(posedge clk); #1;
    valid_in = 1'b1; funct3 = F3_DIV; is_w = 1'b0; src1_in = 64'd99999; src2_in = 64'd13;
    repeat (10) begin @(posedge clk); #1 valid_in = 1'b0; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_midop_reset got %b want 0", busy);
    end
    repeat (70) begin @(negedge clk); if (valid_out) vo++; end
    checks++;
    if (vo != 0) begin
      errors++;
      $display("FAIL valid_out_after_reset got %0d pulses want 0", vo);
    end
  endtask

  task automatic test_directed;
    run_op(F3_MULH, 1'b0, '1, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_op(F3_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op(F3_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op(F3_DIVU, 1'b0, 64'd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_op(F3_REMU, 1'b0, 64'd5, 64'd0, 1'b1, 64'd5, 2);
    run_op(F3_DIV,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000, 2);
    run_op(F3_REM,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'h0, 2);
    run_op(F3_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 64'h8000_0000_0000_0000, 2);
  endtask

  task automatic test_random;
    logic [2:0] f;
    logic w;
    logic [63:0] a, b;
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 1) && (f == F3_MUL || f[2]);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = w ? {$urandom, 32'h0} : 64'h0;
        1: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
        end
        2: b = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(1, 100)) : -64'($urandom_range(1, 100));
        3: a = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(f, w, a, b, 1'b0, 64'h0, 0);
    end
  endtask

  task automatic test_flush;
    int vo;
    logic [63:0] a, b;
    vo = 0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    @(posedge clk); #1;
    valid_in = 1'b1; funct3 = F3_DIV; is_w = 1'b0; src1_in = 64'd1000; src2_in = 64'd7;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (k == 30) flush = 1'b1;
      @(negedge clk);
      if (valid_out) vo++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_cycle30 got %b want 1", busy);
    end
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b1; funct3 = F3_MUL; is_w = 1'b0; src1_in = a; src2_in = b;
    @(negedge clk);
    if (valid_out) vo++;
    checks++;
    if (busy !== 1'b0 || mul_block !== 1'b0) begin
      errors++;
      $display("FAIL after_flush_cycle31 got busy=%b blk=%b want 0 0", busy, mul_block);
    end
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    if (valid_out) vo++;
    checks++;
    if (vo != 0) begin
      errors++;
      $display("FAIL flushed_op_pulse got %0d pulses want 0", vo);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || result !== ref_op(F3_MUL, 1'b0, a, b)) begin
      errors++;
      $display("FAIL mul_after_flush got vo=%b res=%h want 1 %h", valid_out, result, ref_op(F3_MUL, 1'b0, a, b));
    end
    // flush wins over a simultaneous request
    @(posedge clk); #1;
    flush = 1'b1; valid_in = 1'b1; funct3 = F3_MULHU;
    @(negedge clk);
    checks++;
    if (mul_block !== 1'b1) begin
      errors++;
      $display("FAIL flush_vs_valid_blk got %b want 1", mul_block);
    end
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_valid_busy got %b want 0", busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_valid_pulse got %b want 0", valid_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b, c, d, got;
    int lat, blk_bad;
    logic blk_done;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom} | 64'h1;
    c = {$urandom, $urandom};
    d = {$urandom, $urandom};
    lat = 0; blk_bad = 0; blk_done = 1'b1; got = 64'h0;
    @(posedge clk); #1;
    valid_in = 1'b1; funct3 = F3_DIVU; is_w = 1'b0; src1_in = a; src2_in = b;
    @(posedge clk); #1;
    funct3 = F3_MULHSU; src1_in = c; src2_in = d;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (valid_out) begin lat = k; got = result; blk_done = mul_block; break; end
      if (mul_block !== 1'b1) blk_bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (blk_bad != 0) begin
      errors++;
      $display("FAIL held_request_while_busy got %0d unblocked cycles want 0", blk_bad);
    end
    checks++;
    if (lat != 66 || got !== ref_op(F3_DIVU, 1'b0, a, b)) begin
      errors++;
      $display("FAIL b2b_div got lat=%0d res=%h want 66 %h", lat, got, ref_op(F3_DIVU, 1'b0, a, b));
    end
    checks++;
    if (blk_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept_in_done got blk=%b want 0", blk_done);
    end
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mul1 got vo=%b busy=%b want 0 1", valid_out, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || result !== ref_op(F3_MULHSU, 1'b0, c, d)) begin
      errors++;
      $display("FAIL b2b_mul got vo=%b res=%h want 1 %h", valid_out, result, ref_op(F3_MULHSU, 1'b0, c, d));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_back_to_back;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
